// File: rtl/sram_macro_pkg.sv
// ============================================================================
// Module      : sram_macro_pkg
// Description : Elaboration-time helpers for the generic SRAM macro model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_macro_pkg;

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_macro.sv
// ============================================================================
// Module      : sram_macro
// Description : Synchronous single-port SRAM, active-low CEN/WEN/OEN, 1-cycle
//               registered read data, array not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_macro
  import sram_macro_pkg::*;
#(
  parameter int aw    = 32,
  parameter int dw    = 8,
  parameter int depth = 128
) (
  input  logic          HCLK,
  input  logic          HRST_N,
  input  logic          CEN,
  input  logic          WEN,
  input  logic [aw-1:0] A,
  input  logic [dw-1:0] D,
  input  logic          OEN,
  output logic [dw-1:0] Q
);

  localparam int c_iw = $clog2(depth);

  generate
    if (!is_pow2(depth) || (c_iw > aw)) begin : g_bad_params
      $error("sram_macro: depth=%0d must be a power of two >= 2 and fit in aw=%0d bits",
             depth, aw);
    end
  endgenerate

  logic [dw-1:0]   r_mem [depth];
  logic [dw-1:0]   r_q;
  logic [c_iw-1:0] w_index;
  logic            w_ctrl_known;
  logic            w_write;
  logic            w_read;

  assign w_index      = A[c_iw-1:0];
  // Unknown control must neither write the array nor update Q.
  assign w_ctrl_known = !$isunknown({CEN, WEN});
  assign w_write      = w_ctrl_known && !CEN && !WEN;
  assign w_read       = w_ctrl_known && !CEN &&  WEN;

  always_ff @(posedge HCLK) begin
    if (HRST_N && w_write) begin
      r_mem[w_index] <= D;
    end
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      r_q <= '0;
    end else begin
      assert (w_ctrl_known)
        else $error("sram_macro: X on CEN/WEN, access ignored");
      if (w_read) begin
        r_q <= OEN ? '0 : r_mem[w_index];
      end
    end
  end

  assign Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_macro.sv
// ============================================================================
// Module      : tb_sram_macro
// Description : Directed self-checking bench for sram_macro (depth=128, dw=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_macro;

  logic        HCLK;
  logic        HRST_N;
  logic        CEN;
  logic        WEN;
  logic [31:0] A;
  logic [7:0]  D;
  logic        OEN;
  logic [7:0]  Q;

  int checks;
  int failures;

  sram_macro #(.aw(32), .dw(8), .depth(128)) dut (
    .HCLK  (HCLK),
    .HRST_N(HRST_N),
    .CEN   (CEN),
    .WEN   (WEN),
    .A     (A),
    .D     (D),
    .OEN   (OEN),
    .Q     (Q)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Present one operation, then advance to 1 time unit past the rising edge.
  task automatic cyc(input logic cen, input logic wen, input logic [31:0] addr,
                     input logic [7:0] data, input logic oen);
    CEN = cen;
    WEN = wen;
    A   = addr;
    D   = data;
    OEN = oen;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    HRST_N   = 1'b0;
    CEN = 1'b1; WEN = 1'b1; A = '0; D = '0; OEN = 1'b0;

    repeat (2) @(posedge HCLK);
    #1;
    check("reset_q", Q, 8'h00);
    HRST_N = 1'b1;

    cyc(1'b0, 1'b0, 32'd3, 8'hA5, 1'b0);
    check("write_holds_q", Q, 8'h00);
    cyc(1'b0, 1'b1, 32'd3, 8'h00, 1'b0);
    check("read_a3", Q, 8'hA5);

    cyc(1'b0, 1'b1, 32'd3, 8'h00, 1'b1);
    check("oen_mask", Q, 8'h00);
    cyc(1'b0, 1'b1, 32'd3, 8'h00, 1'b0);
    check("oen_unmask", Q, 8'hA5);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, i[0], 32'd3, 8'hF0 + 8'(i), i[1]);
      check("idle_hold", Q, 8'hA5);
    end
    cyc(1'b0, 1'b1, 32'd3, 8'h00, 1'b0);
    check("idle_array_kept", Q, 8'hA5);

    cyc(1'b0, 1'b0, 32'h0000_0085, 8'h3C, 1'b0);
    cyc(1'b0, 1'b1, 32'd5, 8'h00, 1'b0);
    check("wrap_read", Q, 8'h3C);
    cyc(1'b0, 1'b1, 32'hFFFF_FF83, 8'h00, 1'b0);
    check("wrap_high_bits", Q, 8'hA5);

    cyc(1'b0, 1'b0, 32'd10, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, 32'd10, 8'h00, 1'b0);
    check("pre_reset_q", Q, 8'h5A);
    #2;
    HRST_N = 1'b0;
    #1;
    check("async_reset_q", Q, 8'h00);
    cyc(1'b0, 1'b0, 32'd10, 8'h11, 1'b0);
    check("reset_write_q", Q, 8'h00);
    HRST_N = 1'b1;
    cyc(1'b0, 1'b1, 32'd10, 8'h00, 1'b0);
    check("reset_write_blocked", Q, 8'h5A);

    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 1'b0, 32'(i), 8'(i), 1'b0);
    end
    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 1'b1, 32'(i), 8'h00, 1'b0);
      check("b2b_read", Q, 8'(i));
    end

    cyc(1'b1, 1'b1, 32'd0, 8'h00, 1'b0);
    check("final_idle", Q, 8'd127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "tb_sram_macro: time limit reached");
  end

endmodule

`default_nettype wire

// File: doc/sram_macro.md
# sram_macro

Synchronous single-port SRAM behavioural model with active-low chip enable, write enable and output enable. It is the storage element behind the AHB SRAM slave, which uses four 8-bit instances, one per byte lane. Each access (read or write) is one clock edge. Read data is registered, so it is valid in the cycle after the address is presented. That cycle is the AHB data phase.

## Interface
Parameters:
- aw, 32: width of address port A
- dw, 8: data width of D and Q
- depth, 128: number of words; power of two, ≥2; depth ≤ 2^aw

Ports:
- HCLK  input  1  clock; all state updates on rising edge
- HRST_N  input  1  reset, asynchronous, active-low
- CEN  input  1  chip enable, active-low
- WEN  input  1  write enable, active-low; meaningful only when CEN=0
- A  input  aw  word address; only the low log2(depth) bits are used
- D  input  dw  write data
- OEN  input  1  read-lane enable, active-low; sampled with the read
- Q  output  dw  registered read data

## Operation
- Array: depth × dw bits. The array is not reset, and contents persist across HRST_N. Simulation initial contents are X.
- Index: A[log2(depth)-1:0]. Upper address bits are ignored, so addresses wrap modulo depth.
- Write: at a rising edge with CEN=0 and WEN=0, mem[index] <= D. Q holds its value and OEN is ignored.
- Read: at a rising edge with CEN=0 and WEN=1:
  - if OEN=0, Q <= mem[index];
  - if OEN=1, Q <= 0, so a disabled byte lane returns zero.
- Idle: with CEN=1 the array and Q are unchanged, and WEN, OEN, A and D are don't-care.
- Q is never high-Z. It is a plain registered output.
- There is no read-during-write path, because one port performs one operation per edge. A read of an address one cycle after a write to it returns the new data.
- X on CEN or WEN while HRST_N=1 is a simulation error: display a message and leave the array unchanged.

## Timing
- Reset: while HRST_N=0, Q=0 immediately (asynchronous), and writes are blocked. Deassertion takes effect on the next rising edge.
- Read latency: 1 cycle. A, CEN, WEN and OEN are presented before edge N, and Q is valid after edge N until the next read edge.
- Write latency: 0 cycles. Data is in the array after edge N and is readable by a read issued at edge N+1, with Q valid after N+1.
- Back-to-back operations every cycle are supported with no bubbles.
- Reset asserted mid-operation: Q clears at once. A write whose edge coincides with reset assertion does not occur.

## Structure
- Single module; no sub-module needed.
- Derive the index width internally as $clog2(depth).
- No shared package. If the team package defines byte-lane constants (dw=8, 4 lanes), the AHB wrapper imports them; this block stays generic.
- Elaboration-time checks: depth is a power of two, and $clog2(depth) ≤ aw.

## Test plan
- Reset: HRST_N=0 mid-simulation with Q=8'h5A → Q=0 immediately. A write attempted during reset leaves the array unchanged on readback.
- Write/read: write D=8'hA5 at A=3, then on the next cycle read A=3 with OEN=0 → Q=8'hA5 one cycle after the read edge.
- OEN masking: read A=3 with OEN=1 → Q=8'h00. The next read with OEN=0 → Q=8'hA5.
- Wrap-around: with depth=128, write 8'h3C at A=32'h0000_0085 → a read at A=5 returns 8'h3C.
- Idle hold: after a read gives Q=8'hA5, hold CEN=1 while toggling WEN, A and D for 5 cycles → Q stays 8'hA5 and the array is unchanged.
- Back-to-back: write A=0..127 with D=index on consecutive cycles, then read them consecutively → Q=index, each one cycle after its read edge, with no gaps.
